tlp_demux_n: RTL and testbench

Parametrised successor to the two-port read/write TLP demultiplexer. It accepts a single beat-oriented TLP stream (header + payload, sop/eop, valid/ready) and routes whole packets to one of PORTS output channels, chosen by the header Fmt/Type decode. Each channel has its own output FIFO, so a stalled consumer does not block packets bound for other ports until that port's FIFO fills. Unroutable TLPs are consumed and dropped, and counted. The block sits between the TLP receive path and the AXI-side master engines (read, write, completion, message).

---
 rtl/tlp_pkg.sv | 44 ++++
 rtl/tlp_demux_n_fifo.sv | 51 +++++
 rtl/tlp_demux_n.sv | 132 +++++++++++++
 tb/tb_tlp_demux_n.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlp_pkg.sv
// Shared TLP decode constants and the Fmt/Type routing function for the TLP demultiplexer.
package tlp_pkg;

  localparam int unsigned FMT_OFF  = 29;
  localparam int unsigned TYPE_OFF = 24;

  localparam logic [4:0] TLP_TYPE_MEM     = 5'b00000;
  localparam logic [4:0] TLP_TYPE_CPL     = 5'b01010;
  localparam logic [1:0] TLP_TYPE_MSG_MSB = 2'b10;

  localparam logic [1:0] PORT_RD  = 2'd0;
  localparam logic [1:0] PORT_WR  = 2'd1;
  localparam logic [1:0] PORT_CPL = 2'd2;
  localparam logic [1:0] PORT_MSG = 2'd3;

  typedef struct packed {
    logic       drop;
    logic [1:0] port;
  } route_t;

  typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DROP} state_t;

  function automatic route_t tlp_route(input logic [2:0] fmt, input logic [4:0] typ,
                                       input int unsigned ports);
    route_t r;
    r.drop = 1'b1;
    r.port = PORT_RD;
    if (typ == TLP_TYPE_MEM && fmt[2:1] == 2'b00) begin
      r.drop = 1'b0;
      r.port = PORT_RD;
    end else if (typ == TLP_TYPE_MEM && fmt[2:1] == 2'b01) begin
      r.drop = 1'b0;
      r.port = PORT_WR;
    end else if (typ == TLP_TYPE_CPL && ports >= 3) begin
      r.drop = 1'b0;
      r.port = PORT_CPL;
    end else if (typ[4:3] == TLP_TYPE_MSG_MSB && ports == 4) begin
      r.drop = 1'b0;
      r.port = PORT_MSG;
    end
    return r;
  endfunction

endpackage

// File: rtl/tlp_demux_n_fifo.sv
// Single-clock FIFO per output channel; a write into a full FIFO is refused even if a read pops that cycle.
module tlp_port_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_wr      = i_wr_en && !o_full;
  assign w_rd      = i_rd_en && !o_empty;
  // Masked so an empty channel presents all-zero data/header/flags
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/tlp_demux_n.sv
// Routes whole TLPs from one beat stream to PORTS buffered output channels by Fmt/Type.
module tlp_demux_n
  import tlp_pkg::*;
#(
  parameter int unsigned PORTS        = 2,
  parameter int unsigned DOUBLE_WORD  = 32,
  parameter int unsigned HEADER_SIZE  = 4*DOUBLE_WORD,
  parameter int unsigned PAYLOAD_SIZE = 8*DOUBLE_WORD,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [PAYLOAD_SIZE-1:0]       in_data,
  input  logic [HEADER_SIZE-1:0]        in_hdr,
  input  logic                          in_sop,
  input  logic                          in_eop,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [PORTS*PAYLOAD_SIZE-1:0] out_data,
  output logic [PORTS*HEADER_SIZE-1:0]  out_hdr,
  output logic [PORTS-1:0]              out_sop,
  output logic [PORTS-1:0]              out_eop,
  output logic [PORTS-1:0]              out_valid,
  input  logic [PORTS-1:0]              out_ready,
  output logic [CNT_W-1:0]              drop_cnt,
  output logic [CNT_W-1:0]              err_cnt
);
  localparam int unsigned FW = HEADER_SIZE + PAYLOAD_SIZE + 2;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [1:0]             r_port;
  logic [HEADER_SIZE-1:0] r_hdr;
  logic [CNT_W-1:0]       r_drop_cnt;
  logic [CNT_W-1:0]       r_err_cnt;

  route_t                 w_route;
  logic [PORTS-1:0]       w_full;
  logic [PORTS-1:0]       w_empty;
  logic [PORTS-1:0]       w_wr_en;
  logic [3:0]             w_full_ext;
  logic                   w_idle_ok;
  logic                   w_ready;
  logic                   w_accept;
  logic                   w_new_pkt;
  logic                   w_err;
  logic                   w_fwd_beat;
  logic [1:0]             w_wr_port;
  logic [HEADER_SIZE-1:0] w_wr_hdr;

  assign w_route = tlp_route(in_hdr[HEADER_SIZE-DOUBLE_WORD+FMT_OFF +: 3],
                             in_hdr[HEADER_SIZE-DOUBLE_WORD+TYPE_OFF +: 5], PORTS);
  assign w_full_ext = 4'(w_full);
  assign w_idle_ok  = enable && (w_route.drop || !w_full_ext[w_route.port]);

  // A stray sop inside a packet closes it and is admitted exactly like an idle sop
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      ST_IDLE: w_ready = w_idle_ok;
      ST_FWD:  w_ready = in_sop ? w_idle_ok : !w_full_ext[r_port];
      ST_DROP: w_ready = in_sop ? w_idle_ok : 1'b1;
      default: w_ready = 1'b0;
    endcase
  end

  assign in_ready   = rst_n && w_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_new_pkt  = w_accept && in_sop;
  assign w_err      = w_accept && (in_sop ? (r_state != ST_IDLE) : (r_state == ST_IDLE));
  assign w_fwd_beat = w_new_pkt ? !w_route.drop : (w_accept && r_state == ST_FWD);
  assign w_wr_port  = in_sop ? w_route.port : r_port;
  assign w_wr_hdr   = in_sop ? in_hdr : r_hdr;

  always_comb begin
    w_state_nxt = r_state;
    if (w_new_pkt)
      w_state_nxt = in_eop ? ST_IDLE : (w_route.drop ? ST_DROP : ST_FWD);
    else if (w_accept && in_eop)
      w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_port     <= '0;
      r_hdr      <= '0;
      r_drop_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_new_pkt) begin
        r_port <= w_route.port;
        r_hdr  <= in_hdr;
      end
      if (w_new_pkt && w_route.drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
      if (w_err && r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign drop_cnt = r_drop_cnt;
  assign err_cnt  = r_err_cnt;

  for (genvar p = 0; p < PORTS; p++) begin : g_port
    logic [FW-1:0] w_rd_data;

    assign w_wr_en[p] = w_fwd_beat && (w_wr_port == 2'(p));

    tlp_port_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (w_wr_en[p]),
      .i_wr_data ({w_wr_hdr, in_data, in_sop, in_eop}),
      .i_rd_en   (out_ready[p]),
      .o_rd_data (w_rd_data),
      .o_full    (w_full[p]),
      .o_empty   (w_empty[p])
    );

    assign out_hdr[p*HEADER_SIZE +: HEADER_SIZE]    = w_rd_data[FW-1 -: HEADER_SIZE];
    assign out_data[p*PAYLOAD_SIZE +: PAYLOAD_SIZE] = w_rd_data[2 +: PAYLOAD_SIZE];
    assign out_sop[p]   = w_rd_data[1];
    assign out_eop[p]   = w_rd_data[0];
    assign out_valid[p] = !w_empty[p];
  end

endmodule

// File: tb/tb_tlp_demux_n.sv
// Randomized bench for tlp_demux_n: a 4-port and a 2-port instance share one stimulus stream selected by sel.
module tb_tlp_demux_n;

  typedef struct packed {
    logic [127:0] hdr;
    logic [255:0] data;
    logic         sop;
    logic         eop;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n, enable, sel;
  logic [255:0] in_data;
  logic [127:0] in_hdr;
  logic in_sop, in_eop, in_valid;
  logic a_in_valid, b_in_valid, a_in_ready, b_in_ready, cur_ready;

  logic [1023:0] a_out_data;
  logic [511:0]  a_out_hdr;
  logic [3:0]    a_out_sop, a_out_eop, a_out_valid, a_out_ready, fix_rdy, rnd_val;
  logic [7:0]    a_drop_cnt, a_err_cnt;
  logic [511:0]  b_out_data;
  logic [255:0]  b_out_hdr;
  logic [1:0]    b_out_sop, b_out_eop, b_out_valid;
  logic [7:0]    b_drop_cnt, b_err_cnt;
  logic          rnd_rdy;

  int checks = 0;
  int fails  = 0;

  beat_t exp_q[8][$];
  beat_t obs_q[8][$];
  bit           m_open[2];
  int           m_port[2];
  logic [127:0] m_hdr[2];
  int           m_drop[2];
  int           m_err[2];

  always #5 clk = ~clk;

  assign a_in_valid  = in_valid & ~sel;
  assign b_in_valid  = in_valid & sel;
  assign cur_ready   = sel ? b_in_ready : a_in_ready;
  assign a_out_ready = rnd_rdy ? rnd_val : fix_rdy;

  tlp_demux_n #(.PORTS(4), .FIFO_DEPTH(4), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_data(in_data), .in_hdr(in_hdr),
    .in_sop(in_sop), .in_eop(in_eop), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_hdr(a_out_hdr), .out_sop(a_out_sop), .out_eop(a_out_eop),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .drop_cnt(a_drop_cnt), .err_cnt(a_err_cnt));

  tlp_demux_n #(.PORTS(2), .FIFO_DEPTH(4), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_data(in_data), .in_hdr(in_hdr),
    .in_sop(in_sop), .in_eop(in_eop), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_hdr(b_out_hdr), .out_sop(b_out_sop), .out_eop(b_out_eop),
    .out_valid(b_out_valid), .out_ready(2'b11), .drop_cnt(b_drop_cnt), .err_cnt(b_err_cnt));

  always begin
    @(posedge clk);
    #1;
    rnd_val = 4'($urandom);
  end

  // Capture beats that will transfer on the coming edge
  always @(negedge clk) begin
    for (int p = 0; p < 4; p++)
      if (a_out_valid[p] && a_out_ready[p])
        obs_q[p].push_back({a_out_hdr[p*128 +: 128], a_out_data[p*256 +: 256], a_out_sop[p], a_out_eop[p]});
    for (int p = 0; p < 2; p++)
      if (b_out_valid[p])
        obs_q[4+p].push_back({b_out_hdr[p*128 +: 128], b_out_data[p*256 +: 256], b_out_sop[p], b_out_eop[p]});
  end

  function automatic int ref_route(input logic [31:0] dw0, input int ports);
    logic [2:0] f = dw0[31:29];
    logic [4:0] t = dw0[28:24];
    if (t == 5'd0 && f <= 3'd1) return 0;
    if (t == 5'd0 && (f == 3'd2 || f == 3'd3)) return 1;
    if (t == 5'd10) return (ports >= 3) ? 2 : -1;
    if (t >= 5'd16 && t <= 5'd23) return (ports == 4) ? 3 : -1;
    return -1;
  endfunction

  task automatic model_accept(input logic [127:0] h, input logic [255:0] d, input bit s, input bit e);
    int    i = sel ? 1 : 0;
    int    r;
    beat_t b;
    if (s) begin
      if (m_open[i] && m_err[i] < 255) m_err[i]++;
      r = ref_route(h[127:96], i ? 2 : 4);
      if (r < 0) begin
        if (m_drop[i] < 255) m_drop[i]++;
      end else begin
        b.hdr = h; b.data = d; b.sop = 1'b1; b.eop = e;
        exp_q[i*4+r].push_back(b);
      end
      m_open[i] = !e;
      m_port[i] = r;
      m_hdr[i]  = h;
    end else if (!m_open[i]) begin
      if (m_err[i] < 255) m_err[i]++;
    end else begin
      if (m_port[i] >= 0) begin
        b.hdr = m_hdr[i]; b.data = d; b.sop = 1'b0; b.eop = e;
        exp_q[i*4+m_port[i]].push_back(b);
      end
      if (e) m_open[i] = 1'b0;
    end
  endtask

  function automatic bit q_match(input int i);
    if (exp_q[i].size() != obs_q[i].size()) return 1'b0;
    for (int k = 0; k < exp_q[i].size(); k++)
      if (exp_q[i][k] !== obs_q[i][k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] mk_hdr(input logic [31:0] dw0);
    return {dw0, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [31:0] rnd_dw0(input int kind);
    logic [2:0] f = 3'($urandom);
    logic [4:0] t;
    case (kind)
      0: begin f = {2'b00, 1'($urandom)}; t = 5'd0; end
      1: begin f = {2'b01, 1'($urandom)}; t = 5'd0; end
      2: t = 5'b01010;
      3: t = {2'b10, 3'($urandom)};
      default: begin
        case ($urandom_range(0, 3))
          0: t = 5'b00100;
          1: t = 5'b00010;
          2: t = 5'b11011;
          default: begin f = {1'b1, 2'($urandom)}; t = 5'd0; end
        endcase
      end
    endcase
    return {f, t, 24'($urandom)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_open[i] = 1'b0; m_port[i] = -1; m_hdr[i] = '0; m_drop[i] = 0; m_err[i] = 0;
    end
    for (int i = 0; i < 8; i++) begin
      exp_q[i].delete();
      obs_q[i].delete();
    end
  endtask

  // Caller is at posedge+1; returns at posedge+1 after the acceptance edge
  task automatic send_beat(input logic [127:0] h, input logic [255:0] d, input bit s, input bit e);
    int n = 0;
    in_hdr = h; in_data = d; in_sop = s; in_eop = e; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (cur_ready === 1'b1) begin
        model_accept(h, d, s, e);
        break;
      end
      n++;
      if (n >= 300) begin
        checks++; fails++;
        $display("FAIL send_timeout: in_ready=%0b, want 1 within 300 cycles", cur_ready);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] dw0, input int len);
    logic [127:0] h = mk_hdr(dw0);
    for (int k = 0; k < len; k++)
      send_beat((k == 0) ? h : mk_hdr($urandom), rnd256(), k == 0, k == len - 1);
  endtask

  task automatic drain_and_compare(input string name);
    repeat (12) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (!q_match(i)) begin
        fails++;
        $display("FAIL %s queue%0d: got %0d beats, want %0d matching beats", name, i, obs_q[i].size(), exp_q[i].size());
      end
      exp_q[i].delete();
      obs_q[i].delete();
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({a_in_ready, b_in_ready} !== 2'b00) begin
      fails++; $display("FAIL reset_in_ready: got %b, want 00", {a_in_ready, b_in_ready});
    end
    checks++;
    if ({a_out_valid, b_out_valid} !== 6'd0 || a_out_data !== '0 || a_out_hdr !== '0 || a_out_sop !== 4'd0) begin
      fails++; $display("FAIL reset_outputs: got valid=%b, want all zero outputs", {a_out_valid, b_out_valid});
    end
    checks++;
    if ({a_drop_cnt, a_err_cnt, b_drop_cnt, b_err_cnt} !== 32'd0) begin
      fails++; $display("FAIL reset_counters: got %h, want 0", {a_drop_cnt, a_err_cnt, b_drop_cnt, b_err_cnt});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (a_in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_release_ready: got %b, want 1", a_in_ready);
    end
  endtask

  task automatic test_basic();
    logic [127:0] h;
    sel = 1'b1;
    send_beat(mk_hdr(32'h0000_0001), rnd256(), 1'b1, 1'b1);
    checks++;
    if ({b_out_valid[0], b_out_sop[0], b_out_eop[0]} !== 3'b111) begin
      fails++; $display("FAIL basic_mrd_latency: got v/s/e=%b, want 111", {b_out_valid[0], b_out_sop[0], b_out_eop[0]});
    end
    h = mk_hdr(32'h4000_0002);
    for (int k = 0; k < 3; k++) begin
      send_beat((k == 0) ? h : mk_hdr($urandom), rnd256(), k == 0, k == 2);
      checks++;
      if ({b_out_valid[1], b_out_sop[1], b_out_eop[1], b_out_hdr[255:128]} !== {1'b1, k == 0, k == 2, h}) begin
        fails++;
        $display("FAIL basic_mwr_beat%0d: got v/s/e=%b, want %b", k, {b_out_valid[1], b_out_sop[1], b_out_eop[1]}, {1'b1, k == 0, k == 2});
      end
    end
    drain_and_compare("basic");
    checks++;
    if (b_drop_cnt !== 8'd0) begin
      fails++; $display("FAIL basic_drop_cnt: got %0d, want 0", b_drop_cnt);
    end
  endtask

  task automatic test_drop();
    sel = 1'b1;
    send_beat(mk_hdr(32'h4A00_0001), rnd256(), 1'b1, 1'b1);
    checks++;
    if (b_out_valid !== 2'b00 || b_drop_cnt !== 8'(m_drop[1])) begin
      fails++; $display("FAIL drop_cpl: got valid=%b drop=%0d, want 00 and %0d", b_out_valid, b_drop_cnt, m_drop[1]);
    end
    for (int n = 0; n < 300; n++)
      send_pkt(rnd_dw0($urandom_range(2, 4)), $urandom_range(1, 2));
    drain_and_compare("drop");
    checks++;
    if (b_drop_cnt !== 8'hFF || m_drop[1] != 255) begin
      fails++; $display("FAIL drop_saturate: got %0d, want 255", b_drop_cnt);
    end
  endtask

  task automatic test_stall();
    logic [127:0] h;
    logic [255:0] d;
    sel = 1'b0;
    fix_rdy = 4'b1101;
    for (int n = 0; n < 4; n++) send_pkt(32'h4000_0000 | 32'(n), 1);
    h = mk_hdr(32'h4000_0005);
    d = rnd256();
    in_hdr = h; in_data = d; in_sop = 1'b1; in_eop = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (a_in_ready !== 1'b0 || a_out_valid[1] !== 1'b1 || a_out_data[256 +: 256] !== exp_q[1][0].data) begin
        fails++;
        $display("FAIL stall_hold%0d: got ready=%b valid1=%b, want ready=0 valid1=1 with stable data", c, a_in_ready, a_out_valid[1]);
      end
    end
    @(posedge clk); #1;
    fix_rdy = 4'hF;
    send_beat(h, d, 1'b1, 1'b1);
    send_pkt(32'h0000_0009, 1);
    drain_and_compare("stall");
  endtask

  task automatic test_ports();
    sel = 1'b0;
    send_pkt(32'h4A00_0001, 2);
    send_pkt(32'h3400_0000, 1);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (obs_q[2].size() !== 2 || obs_q[3].size() !== 1 || obs_q[0].size() !== 0 || obs_q[1].size() !== 0) begin
      fails++;
      $display("FAIL ports_cpl_msg: got beats p0..p3=%0d,%0d,%0d,%0d, want 0,0,2,1", obs_q[0].size(), obs_q[1].size(), obs_q[2].size(), obs_q[3].size());
    end
    drain_and_compare("ports");
  endtask

  task automatic test_enable();
    logic [127:0] h;
    logic [255:0] d;
    sel = 1'b0;
    h = mk_hdr(32'h6000_0010);
    for (int k = 0; k < 4; k++) begin
      if (k == 2) enable = 1'b0;
      send_beat((k == 0) ? h : mk_hdr($urandom), rnd256(), k == 0, k == 3);
    end
    h = mk_hdr(32'h2000_0011);
    d = rnd256();
    in_hdr = h; in_data = d; in_sop = 1'b1; in_eop = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (a_in_ready !== 1'b0) begin
        fails++; $display("FAIL enable_block%0d: got in_ready=%b, want 0", c, a_in_ready);
      end
    end
    @(posedge clk); #1;
    enable = 1'b1;
    send_beat(h, d, 1'b1, 1'b1);
    send_beat('0, rnd256(), 1'b0, 1'b1);
    drain_and_compare("enable");
    checks++;
    if (a_err_cnt !== 8'd1 || a_err_cnt !== 8'(m_err[0])) begin
      fails++; $display("FAIL enable_err_cnt: got %0d, want 1", a_err_cnt);
    end
  endtask

  task automatic test_random();
    int len, cut;
    sel = 1'b0;
    rnd_rdy = 1'b1;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 19) == 0)
        send_beat(mk_hdr($urandom), rnd256(), 1'b0, 1'($urandom));
      len = $urandom_range(1, 4);
      cut = ($urandom_range(0, 9) == 0) ? $urandom_range(1, len) : len;
      begin
        logic [127:0] h = mk_hdr(rnd_dw0($urandom_range(0, 4)));
        for (int k = 0; k < cut; k++)
          send_beat((k == 0) ? h : mk_hdr($urandom), rnd256(), k == 0, k == len - 1);
      end
    end
    rnd_rdy = 1'b0;
    fix_rdy = 4'hF;
    drain_and_compare("random");
    checks++;
    if (a_drop_cnt !== 8'(m_drop[0]) || a_err_cnt !== 8'(m_err[0])) begin
      fails++;
      $display("FAIL random_counters: got drop=%0d err=%0d, want drop=%0d err=%0d", a_drop_cnt, a_err_cnt, m_drop[0], m_err[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] h;
    sel = 1'b0;
    // close any packet the random run left open
    send_beat('0, rnd256(), 1'b0, 1'b1);
    fix_rdy = 4'h0;
    send_pkt(32'h0000_0020, 1);
    send_pkt(32'h0000_0021, 1);
    h = mk_hdr(32'h4000_0022);
    send_beat(h, rnd256(), 1'b1, 1'b0);
    in_hdr = mk_hdr($urandom); in_data = rnd256(); in_sop = 1'b0; in_eop = 1'b0; in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 4'd0 || a_out_data !== '0 || a_in_ready !== 1'b0) begin
      fails++; $display("FAIL reset_mid_outputs: got valid=%b ready=%b, want 0000 and 0", a_out_valid, a_in_ready);
    end
    checks++;
    if ({a_drop_cnt, a_err_cnt, b_drop_cnt} !== 24'd0) begin
      fails++; $display("FAIL reset_mid_counters: got %h, want 0", {a_drop_cnt, a_err_cnt, b_drop_cnt});
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
    fix_rdy = 4'hF;
    @(posedge clk); #1;
    send_pkt(32'h0000_0030, 1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs_q[0].size() !== 1 || obs_q[1].size() !== 0) begin
      fails++; $display("FAIL reset_mid_fresh: got p0=%0d p1=%0d beats, want 1 and 0", obs_q[0].size(), obs_q[1].size());
    end
    drain_and_compare("reset_mid");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b1; sel = 1'b0; rnd_rdy = 1'b0; fix_rdy = 4'hF;
    in_data = '0; in_hdr = '0; in_sop = 1'b0; in_eop = 1'b0; in_valid = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_drop();
    test_stall();
    test_ports();
    test_enable();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
